// File: rtl/tdm_demux4_if.sv
// Bundle of the serial beat input and the per-channel demultiplexed outputs of tdm_demux4.
// The master side drives the beat stream; the slave side is the demultiplexer.
interface tdm_demux4_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             frame_sync;
  logic [WIDTH-1:0] y0;
  logic [WIDTH-1:0] y1;
  logic [WIDTH-1:0] y2;
  logic [WIDTH-1:0] y3;
  logic [3:0]       vld;
  logic             s1;
  logic             s0;
  logic             locked;
  logic             frame_done;
  logic             sync_err;

  modport master (
    output din, din_valid, frame_sync,
    input  y0, y1, y2, y3, vld, s1, s0, locked, frame_done, sync_err
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output y0, y1, y2, y3, vld, s1, s0, locked, frame_done, sync_err
  );
endinterface

// File: rtl/tdm_demux4.sv
// Receive side of a 4-slot TDM link: steers each beat to a registered channel output
// and tracks frame alignment with a HUNT/LOCK state machine.
module tdm_demux4 #(
  parameter int WIDTH       = 1,
  parameter int STRICT_SYNC = 1
) (
  input logic          clk,
  input logic          rst,
  tdm_demux4_if.slave  bus
);

  typedef enum logic {HUNT, LOCK} state_t;

  state_t           state;
  logic [1:0]       slot;
  logic [WIDTH-1:0] y_q [4];
  logic [3:0]       vld_q;
  logic             frame_done_q;
  logic             sync_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= HUNT;
      slot         <= 2'b00;
      vld_q        <= 4'b0000;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      // NOTE: the channel registers are held outputs with defined reset values, so they are
      // cleared element by element here rather than left as an unreset storage array.
      for (int k = 0; k < 4; k++) y_q[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below reads the slot and
      // state from before this edge and the pulse defaults can be overridden safely.
      vld_q        <= 4'b0000;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      if (bus.din_valid) begin
        unique case (state)
          HUNT: begin
            if (bus.frame_sync) begin
              y_q[0] <= bus.din;
              vld_q  <= 4'b0001;
              slot   <= 2'b01;
              state  <= LOCK;
            end
          end
          LOCK: begin
            if (bus.frame_sync && slot != 2'b00) begin
              // Early sync: restart the frame at slot 00, keeping channels already written.
              sync_err_q <= 1'b1;
              y_q[0]     <= bus.din;
              vld_q      <= 4'b0001;
              slot       <= 2'b01;
            end else if (!bus.frame_sync && slot == 2'b00 && STRICT_SYNC != 0) begin
              sync_err_q <= 1'b1;
              slot       <= 2'b00;
              state      <= HUNT;
            end else begin
              y_q[slot]    <= bus.din;
              vld_q        <= 4'b0001 << slot;
              frame_done_q <= (slot == 2'b11);
              slot         <= slot + 2'b01;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  assign bus.y0         = y_q[0];
  assign bus.y1         = y_q[1];
  assign bus.y2         = y_q[2];
  assign bus.y3         = y_q[3];
  assign bus.vld        = vld_q;
  assign bus.s1         = slot[1];
  assign bus.s0         = slot[0];
  assign bus.locked     = (state == LOCK);
  assign bus.frame_done = frame_done_q;
  assign bus.sync_err   = sync_err_q;

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Clocked 4-channel time-division demultiplexer: the receive end of the 4:1 select path.
- A serial beat stream carries one frame of four slots in select order 00,01,10,11. Slot 00 is marked by frame_sync.
- Each beat is steered to a registered per-channel output with a one-cycle valid strobe.
- Tracks frame alignment with a two-state FSM and flags misalignment.

Parameters:
- WIDTH, 1, data width of din and each y output.
- STRICT_SYNC, 1, 1 = frame_sync required on every slot-00 beat (missing sync drops lock); 0 = free-run after first lock.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- din  input  WIDTH  serial slot data.
- din_valid  input  1  din carries a beat this cycle.
- frame_sync  input  1  qualifies the current beat as slot 00; ignored when din_valid=0.
- y0  output  WIDTH  channel 0 data, held between updates.
- y1  output  WIDTH  channel 1 data, held.
- y2  output  WIDTH  channel 2 data, held.
- y3  output  WIDTH  channel 3 data, held.
- vld  output  4  one-hot strobe; bit k is high for one cycle when yk updates.
- s1  output  1  MSB of the expected next slot.
- s0  output  1  LSB of the expected next slot.
- locked  output  1  FSM is in LOCK.
- frame_done  output  1  one-cycle pulse when slot 11 is captured.
- sync_err  output  1  one-cycle pulse on an alignment violation.

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high, and has priority over all other inputs.
- Reset values:
  - y0..y3=0, vld=0, {s1,s0}=00, locked=0, frame_done=0, sync_err=0.
  - FSM=HUNT.
- Timing: all outputs are registered. A beat sampled at edge N appears on yk/vld[k] after edge N, so latency is 1 cycle. Throughput is one beat per cycle, back-to-back.
- din_valid=0: no state change; y held; vld, frame_done and sync_err are 0.
- HUNT (locked=0):
  - Beats with frame_sync=0 are discarded with no strobe and no error.
  - Beat with frame_sync=1: y0<=din, vld=0001, {s1,s0}<=01, go to LOCK.
- LOCK (locked=1), on each beat with slot = {s1,s0}:
  - Normal beat (slot≠00 and frame_sync=0, or slot=00 and frame_sync=1):
    - y[slot]<=din, vld[slot] pulses.
    - Slot increments modulo 4, so 11 wraps to 00.
    - frame_done=1 when slot=11.
  - frame_sync=1 while slot≠00 (early sync):
    - sync_err=1; partial frame is abandoned; frame_done is not raised.
    - Beat is treated as slot 00: y0<=din, vld=0001, slot<=01. Remain in LOCK.
    - Channels already written this frame keep their new values; no rollback.
  - slot=00, frame_sync=0, STRICT_SYNC=1 (missed sync):
    - sync_err=1; beat discarded; vld=0; go to HUNT; slot<=00.
  - slot=00, frame_sync=0, STRICT_SYNC=0: normal capture into y0.
- Strobe rules:
  - At most one vld bit is high per cycle.
  - frame_done coincides only with vld[3].
  - sync_err may coincide with vld[0] (early sync) or stand alone (missed sync).
- Reset mid-frame: the next cycle shows reset values. The partial frame is lost and a fresh frame_sync is required.
- Width: no arithmetic on data. The slot counter is exactly 2 bits, and wrap is natural overflow.

Test Plan:
- Reset, then frame (din, frame_sync) = (0,1),(1,0),(1,0),(1,0), WIDTH=1, back-to-back -> vld = 0001,0010,0100,1000 on successive cycles; final y0..y3 = 0,1,1,1; frame_done high only with vld=1000; locked=1 from the cycle after beat 1; {s1,s0} returns to 00.
- In HUNT, three beats with frame_sync=0 and din=1 -> vld stays 0, y stays 0, locked=0, sync_err=0; then a sync beat with din=1 -> y0=1, vld=0001, locked=1.
- Locked at slot 10, beat din=1 with frame_sync=1 -> sync_err=1 and vld=0001 in the same cycle; y0=1; {s1,s0}=01; no frame_done.
- STRICT_SYNC=1, locked at slot 00, beat with frame_sync=0 -> sync_err=1, vld=0, locked=0, y unchanged. Repeat with STRICT_SYNC=0 -> y0 updated, vld=0001, no sync_err.
- Two full frames with din_valid=0 gaps inserted randomly -> identical y/vld sequence to the gapless run; no strobes in gap cycles.
- rst asserted after slot 01 captured -> next cycle all outputs 0 and locked=0; a following slot-01-type beat (frame_sync=0) is discarded.
